// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 code (g0=111, g1=101).
// Collects one zero-tail terminated frame of DATA_BITS+2 symbols, traces back
// from state 0, then streams the recovered bits out oldest first.
module viterbi_decoder_k3 #(
    parameter int unsigned DATA_BITS = 3,
    parameter int unsigned METRIC_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [1:0]          sym_in,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                bit_out,
    output logic                bit_last,
    output logic [METRIC_W-1:0] err_metric
);
    localparam int unsigned FRAME_LEN = DATA_BITS + 2;
    localparam int unsigned STEP_W    = $clog2(FRAME_LEN);
    localparam int unsigned IDX_W     = $clog2(DATA_BITS + 1);
    localparam logic [METRIC_W-1:0] METRIC_MAX = '1;

    typedef enum logic [1:0] {StRecv, StTrace, StOut} state_e;

    state_e               state;
    logic [STEP_W-1:0]    step;      // symbol index in RECV, traceback index in TRACE
    logic [METRIC_W-1:0]  pm [4];
    logic [METRIC_W-1:0]  pm_new [4];
    logic [3:0]           dec;
    logic [3:0]           surv [FRAME_LEN];
    logic [1:0]           tr_state;
    logic [DATA_BITS-1:0] out_buf;   // out_buf[0] is always the bit currently on bit_out
    logic [DATA_BITS-1:0] out_shift;
    logic [IDX_W-1:0]     out_idx;

    // Hamming distance between the received symbol and the one expected on
    // the branch leaving state s with input b.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic [1:0] s,
                                                 input logic b);
        logic [1:0] diff;
        diff = sym ^ {b ^ s[1] ^ s[0], b ^ s[0]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                    input logic [1:0] bm);
        logic [METRIC_W:0] sum;
        sum = {1'b0, a} + {{(METRIC_W-1){1'b0}}, bm};
        return sum[METRIC_W] ? METRIC_MAX : sum[METRIC_W-1:0];
    endfunction

    assign sym_ready = (state == StRecv);
    assign out_shift = out_buf >> 1;

    // Add-compare-select for all four next states; ties keep the s[0]=0 predecessor.
    always_comb begin
        logic [1:0]          nxt;
        logic [METRIC_W-1:0] cand0;
        logic [METRIC_W-1:0] cand1;
        dec = '0;
        for (int n = 0; n < 4; n++) begin
            pm_new[n] = '0;
        end
        for (int n = 0; n < 4; n++) begin
            nxt   = 2'(n);
            cand0 = sat_add(pm[{nxt[0], 1'b0}], branch_metric(sym_in, {nxt[0], 1'b0}, nxt[1]));
            cand1 = sat_add(pm[{nxt[0], 1'b1}], branch_metric(sym_in, {nxt[0], 1'b1}, nxt[1]));
            dec[nxt]    = (cand1 < cand0);
            pm_new[nxt] = (cand1 < cand0) ? cand1 : cand0;
        end
    end

    // Frame FSM: accumulate metrics/survivors, trace back, then stream bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StRecv;
            step       <= '0;
            pm[0]      <= '0;
            pm[1]      <= METRIC_MAX;
            pm[2]      <= METRIC_MAX;
            pm[3]      <= METRIC_MAX;
            tr_state   <= '0;
            out_buf    <= '0;
            out_idx    <= '0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            bit_last   <= 1'b0;
            err_metric <= '0;
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                surv[i] <= '0;
            end
        end else begin
            unique case (state)
                StRecv: begin
                    if (sym_valid && sym_ready) begin
                        for (int n = 0; n < 4; n++) begin
                            pm[n] <= pm_new[n];
                        end
                        surv[step] <= dec;
                        if (step == STEP_W'(FRAME_LEN - 1)) begin
                            // step stays at L-1: it is the first traceback index
                            err_metric <= pm_new[0];
                            tr_state   <= '0;
                            state      <= StTrace;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                StTrace: begin
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (step == STEP_W'(i)) begin
                            out_buf[i] <= tr_state[1];
                        end
                    end
                    tr_state <= {tr_state[0], surv[step][tr_state]};
                    if (step == '0) begin
                        state     <= StOut;
                        bit_valid <= 1'b1;
                        bit_out   <= tr_state[1];
                        bit_last  <= (DATA_BITS == 1);
                        out_idx   <= '0;
                    end else begin
                        step <= step - 1'b1;
                    end
                end
                StOut: begin
                    if (bit_ready) begin
                        if (out_idx == IDX_W'(DATA_BITS - 1)) begin
                            state     <= StRecv;
                            bit_valid <= 1'b0;
                            bit_out   <= 1'b0;
                            bit_last  <= 1'b0;
                            step      <= '0;
                            pm[0]     <= '0;
                            pm[1]     <= METRIC_MAX;
                            pm[2]     <= METRIC_MAX;
                            pm[3]     <= METRIC_MAX;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_buf  <= out_shift;
                            bit_out  <= out_shift[0];
                            bit_last <= ((out_idx + 1'b1) == IDX_W'(DATA_BITS - 1));
                        end
                    end
                end
                default: state <= StRecv;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench for viterbi_decoder_k3: directed frames from the test
// plan plus random frames compared against a brute-force ML decoder.
module tb_viterbi_decoder_k3;
    localparam int unsigned DATA_BITS = 3;
    localparam int unsigned METRIC_W  = 5;
    localparam int unsigned FRAME_LEN = DATA_BITS + 2;
    localparam logic [DATA_BITS-1:0] LAST_EXP = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic                clk;
    logic                rst_n;
    logic                sym_valid;
    logic                sym_ready;
    logic [1:0]          sym_in;
    logic                bit_valid;
    logic                bit_ready;
    logic                bit_out;
    logic                bit_last;
    logic [METRIC_W-1:0] err_metric;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DATA_BITS-1:0] got_bits;
    logic [DATA_BITS-1:0] got_lasts;
    bit                   got_tmo;
    int                   got_viol;
    int                   got_lat;
    logic                 got_end_valid;
    logic                 got_end_ready;

    viterbi_decoder_k3 #(
        .DATA_BITS(DATA_BITS),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_in    (sym_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .err_metric(err_metric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder from the code definition: symbol i at [2i+1:2i] = {g0, g1}.
    function automatic logic [2*FRAME_LEN-1:0] encode(input logic [DATA_BITS-1:0] data);
        logic [2*FRAME_LEN-1:0] o;
        logic s1, s0, b;
        s1 = 1'b0;
        s0 = 1'b0;
        o  = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            b = (i < DATA_BITS) ? data[i] : 1'b0;
            o[2*i+1] = b ^ s1 ^ s0;
            o[2*i]   = b ^ s0;
            s0 = s1;
            s1 = b;
        end
        return o;
    endfunction

    // Exhaustive maximum-likelihood decode over every possible data word.
    task automatic ml_decode(input logic [2*FRAME_LEN-1:0] rx, output logic [DATA_BITS-1:0] best,
                             output int best_d, output bit uniq);
        int d;
        best   = '0;
        best_d = 2 * FRAME_LEN + 1;
        uniq   = 1'b0;
        for (int c = 0; c < (1 << DATA_BITS); c++) begin
            d = $countones(encode(DATA_BITS'(c)) ^ rx);
            if (d < best_d) begin
                best_d = d;
                best   = DATA_BITS'(c);
                uniq   = 1'b1;
            end else if (d == best_d) begin
                uniq = 1'b0;
            end
        end
    endtask

    // Drive one frame (optional gaps), then collect its bits (optional stall).
    task automatic run_frame(input logic [DATA_BITS-1:0] data, input logic [2*FRAME_LEN-1:0] flip,
                             input int gap, input int stall_at, input int stall_len);
        logic [2*FRAME_LEN-1:0] rx;
        int   waited;
        int   hs;
        logic held_bit;
        logic held_last;
        rx        = encode(data) ^ flip;
        got_tmo   = 1'b0;
        got_viol  = 0;
        got_bits  = '0;
        got_lasts = '0;
        got_lat   = -1;
        hs        = 0;
        bit_ready = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            for (int g = 0; g < gap; g++) begin
                sym_valid = 1'b0;
                sym_in    = 2'($urandom);
                @(posedge clk); #1;
            end
            sym_valid = 1'b1;
            sym_in    = rx[2*i +: 2];
            waited    = 0;
            while (!sym_ready && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!sym_ready) got_tmo = 1'b1;
            hs = cyc;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        sym_in    = 2'($urandom);
        waited    = 0;
        while (!bit_valid && waited < 4 * FRAME_LEN) begin
            if (sym_ready) got_viol++;
            @(posedge clk); #1;
            waited++;
        end
        if (!bit_valid) got_tmo = 1'b1;
        else got_lat = cyc - hs;
        for (int n = 0; n < DATA_BITS && !got_tmo; n++) begin
            if (n == stall_at) begin
                held_bit  = bit_out;
                held_last = bit_last;
                bit_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(posedge clk); #1;
                    if (!bit_valid || bit_out !== held_bit || bit_last !== held_last || sym_ready)
                        got_viol++;
                end
                bit_ready = 1'b1;
            end
            if (!bit_valid) begin
                got_tmo = 1'b1;
            end else begin
                got_bits[n]  = bit_out;
                got_lasts[n] = bit_last;
                if (sym_ready) got_viol++;
                @(posedge clk); #1;
            end
        end
        got_end_valid = bit_valid;
        got_end_ready = sym_ready;
        bit_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sym_ready !== 1'b1 || bit_valid !== 1'b0 || bit_out !== 1'b0 || bit_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b bit=%b last=%b exp 1 0 0 0",
                     sym_ready, bit_valid, bit_out, bit_last);
        end
        checks++;
        if (err_metric !== '0) begin
            failures++;
            $display("FAIL reset_metric got=%0d exp=0", err_metric);
        end
    endtask

    task automatic test_clean();
        run_frame(3'b101, '0, 0, -1, 0);
        checks++;
        if (got_tmo || got_bits !== 3'b101) begin
            failures++;
            $display("FAIL clean_bits got=%b tmo=%0d exp=101", got_bits, got_tmo);
        end
        checks++;
        if (got_lasts !== LAST_EXP) begin
            failures++;
            $display("FAIL clean_last got=%b exp=%b", got_lasts, LAST_EXP);
        end
        checks++;
        if (err_metric !== 5'd0) begin
            failures++;
            $display("FAIL clean_metric got=%0d exp=0", err_metric);
        end
        checks++;
        if (got_lat != FRAME_LEN + 1) begin
            failures++;
            $display("FAIL clean_latency got=%0d exp=%0d", got_lat, FRAME_LEN + 1);
        end
        checks++;
        if (got_viol != 0 || got_end_valid !== 1'b0 || got_end_ready !== 1'b1) begin
            failures++;
            $display("FAIL clean_handshake viol=%0d end_vld=%b end_rdy=%b exp 0 0 1",
                     got_viol, got_end_valid, got_end_ready);
        end
    endtask

    task automatic test_single_error();
        run_frame(3'b101, 10'b10, 0, -1, 0);
        checks++;
        if (got_tmo || got_bits !== 3'b101) begin
            failures++;
            $display("FAIL single_err_bits got=%b tmo=%0d exp=101", got_bits, got_tmo);
        end
        checks++;
        if (err_metric !== 5'd1) begin
            failures++;
            $display("FAIL single_err_metric got=%0d exp=1", err_metric);
        end
    endtask

    task automatic test_patterns();
        logic [DATA_BITS-1:0] pats [2];
        pats[0] = 3'b111;
        pats[1] = 3'b000;
        for (int p = 0; p < 2; p++) begin
            run_frame(pats[p], '0, 0, -1, 0);
            checks++;
            if (got_tmo || got_bits !== pats[p] || err_metric !== 5'd0) begin
                failures++;
                $display("FAIL pattern_%b got=%b metric=%0d tmo=%0d exp=%b metric=0",
                         pats[p], got_bits, err_metric, got_tmo, pats[p]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_frame(3'b101, '0, 0, 1, 3);
        checks++;
        if (got_tmo || got_bits !== 3'b101) begin
            failures++;
            $display("FAIL backpressure_bits got=%b tmo=%0d exp=101", got_bits, got_tmo);
        end
        checks++;
        if (got_viol != 0) begin
            failures++;
            $display("FAIL backpressure_hold violations got=%0d exp=0", got_viol);
        end
        checks++;
        if (got_end_valid !== 1'b0 || got_end_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_end got vld=%b rdy=%b exp 0 1", got_end_valid, got_end_ready);
        end
    endtask

    task automatic test_gaps();
        run_frame(3'b101, '0, 2, -1, 0);
        checks++;
        if (got_tmo || got_bits !== 3'b101 || got_lasts !== LAST_EXP || err_metric !== 5'd0) begin
            failures++;
            $display("FAIL gaps got=%b last=%b metric=%0d exp=101 last=%b metric=0",
                     got_bits, got_lasts, err_metric, LAST_EXP);
        end
        checks++;
        if (got_lat != FRAME_LEN + 1) begin
            failures++;
            $display("FAIL gaps_latency got=%0d exp=%0d", got_lat, FRAME_LEN + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        // Leave a nonzero metric behind so its reset is observable.
        run_frame(3'b101, 10'b10, 0, -1, 0);
        sym_valid = 1'b1;
        sym_in    = 2'b11;
        @(posedge clk); #1;
        sym_in    = 2'b10;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        checks++;
        if (sym_ready !== 1'b1 || bit_valid !== 1'b0 || bit_out !== 1'b0 || bit_last !== 1'b0
            || err_metric !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got rdy=%b vld=%b bit=%b last=%b metric=%0d exp 1 0 0 0 0",
                     sym_ready, bit_valid, bit_out, bit_last, err_metric);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(3'b101, '0, 0, -1, 0);
        checks++;
        if (got_tmo || got_bits !== 3'b101 || got_lasts !== LAST_EXP || err_metric !== 5'd0) begin
            failures++;
            $display("FAIL midreset_frame got=%b last=%b metric=%0d exp=101 last=%b metric=0",
                     got_bits, got_lasts, err_metric, LAST_EXP);
        end
    endtask

    task automatic test_random();
        logic [DATA_BITS-1:0]   data;
        logic [2*FRAME_LEN-1:0] flip;
        logic [DATA_BITS-1:0]   exp_bits;
        int                     exp_d;
        bit                     uniq;
        int                     nerr;
        for (int f = 0; f < 40; f++) begin
            data = DATA_BITS'($urandom);
            flip = '0;
            nerr = int'($urandom_range(0, 4));
            for (int e = 0; e < nerr; e++) flip[$urandom_range(0, 2 * FRAME_LEN - 1)] = 1'b1;
            ml_decode(encode(data) ^ flip, exp_bits, exp_d, uniq);
            run_frame(data, flip, int'($urandom_range(0, 1)), int'($urandom_range(0, DATA_BITS - 1)),
                      int'($urandom_range(0, 2)));
            checks++;
            if (got_tmo || err_metric !== METRIC_W'(exp_d)) begin
                failures++;
                $display("FAIL random_metric frame=%0d got=%0d tmo=%0d exp=%0d",
                         f, err_metric, got_tmo, exp_d);
            end
            if (uniq) begin
                checks++;
                if (got_bits !== exp_bits) begin
                    failures++;
                    $display("FAIL random_bits frame=%0d got=%b exp=%b", f, got_bits, exp_bits);
                end
            end
            checks++;
            if (got_viol != 0 || got_lasts !== LAST_EXP) begin
                failures++;
                $display("FAIL random_flow frame=%0d viol=%0d last=%b exp viol=0 last=%b",
                         f, got_viol, got_lasts, LAST_EXP);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 2'b00;
        bit_ready = 1'b0;
        test_reset();
        test_clean();
        test_single_error();
        test_patterns();
        test_backpressure();
        test_gaps();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
